// File: rtl/ahb_arbiter.sv
// ahb_arbiter: four-master AHB bus arbiter with burst, INCR-length and locked
// transfer tracking.
//
// Ports
//   HCLK       in   bus clock, rising-edge
//   HRESETn    in   asynchronous active-low reset
//   HBUSREQ    in   [3:0] per-master bus request
//   HLOCK      in   [3:0] per-master locked-transfer request
//   HTRANS     in   [1:0] transfer type of the address-phase owner
//   HBURST     in   [2:0] burst type of the address-phase owner
//   HREADY     in   bus ready
//   HGRANT     out  [3:0] one-hot grant (never all-zero)
//   HMASTER    out  [1:0] address-phase owner index (lags HGRANT by one ready beat)
//   HMASTLOCK  out  owner is performing a locked sequence
//
// Configuration
//   AHB_ARB_ROUND_ROBIN_EN  defined   : rotating priority, search starts after the
//                                       last granted master
//                           undefined : fixed priority, master 0 highest
module ahb_arbiter #(
  parameter int DEFAULT_MST = 0,
  parameter int INCR_MAX    = 16
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [3:0] HBUSREQ,
  input  logic [3:0] HLOCK,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  output logic [3:0] HGRANT,
  output logic [1:0] HMASTER,
  output logic       HMASTLOCK
);

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    BURST  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // BUSY (2'b01) needs no decode: it is simply neither a beat nor IDLE.
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] DEF_IDX   = 2'(DEFAULT_MST);
  localparam logic [4:0] INCR_LEN  = 5'(INCR_MAX);

  state_t     state, state_nxt;
  logic [1:0] own_idx, own_nxt;
  logic [4:0] beat_cnt, beat_nxt;
  logic [3:0] cand;
  logic [1:0] search_start;
  logic [1:0] win_idx;
  logic       win_vld, win_lock;
  logic       arb_pt, beat_acc, burst_start, owner_quit;
  logic [4:0] burst_len;

  function automatic logic [4:0] burst_len_f(input logic [2:0] burst);
    case (burst)
      3'b000:         return 5'd1;
      3'b001:         return INCR_LEN;
      3'b010, 3'b011: return 5'd4;
      3'b100, 3'b101: return 5'd8;
      default:        return 5'd16;
    endcase
  endfunction

  // First set bit of cand, scanning upward (modulo 4) from start.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    res = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) res = idx;
    end
    return res;
  endfunction

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                rr_ptr <= DEF_IDX;
    else if (own_nxt != own_idx) rr_ptr <= own_nxt;
  end

  assign search_start = rr_ptr + 2'd1;
`else
  assign search_start = 2'd0;
`endif

  // Masters asking for a locked sequence win over plain requesters.
  assign cand     = (|(HBUSREQ & HLOCK)) ? (HBUSREQ & HLOCK) : HBUSREQ;
  assign win_vld  = |HBUSREQ;
  assign win_idx  = pick(cand, search_start);
  assign win_lock = HLOCK[win_idx] & HBUSREQ[win_idx];

  assign burst_len   = burst_len_f(HBURST);
  assign beat_acc    = HREADY && (HTRANS == TR_NONSEQ || HTRANS == TR_SEQ);
  assign burst_start = HREADY && (HTRANS == TR_NONSEQ) && (burst_len > 5'd1);
  assign owner_quit  = !HBUSREQ[own_idx] && (HTRANS == TR_IDLE);

  always_comb begin
    state_nxt = state;
    own_nxt   = own_idx;
    beat_nxt  = beat_cnt;
    arb_pt    = 1'b0;
    if (HREADY) begin
      case (state)
        PARK: arb_pt = 1'b1;
        OWN: begin
          // The NONSEQ of a burst is its first beat, so the counter holds the
          // beats still to come; the last beat is the one accepted at count 1.
          if (burst_start) begin
            state_nxt = BURST;
            beat_nxt  = burst_len - 5'd1;
          end else begin
            arb_pt = 1'b1;
          end
        end
        BURST: begin
          if (burst_start) begin
            beat_nxt = burst_len - 5'd1;
          end else if (HTRANS == TR_NONSEQ) begin
            state_nxt = OWN;
            beat_nxt  = 5'd0;
          end else if (beat_acc) begin
            if (beat_cnt <= 5'd1) arb_pt = 1'b1;
            else                  beat_nxt = beat_cnt - 5'd1;
          end else if (owner_quit) begin
            arb_pt = 1'b1;
          end
        end
        LOCKED: if (!HLOCK[own_idx]) arb_pt = 1'b1;
        default: arb_pt = 1'b1;
      endcase
      if (arb_pt) begin
        beat_nxt = 5'd0;
        if (win_vld) begin
          own_nxt   = win_idx;
          state_nxt = win_lock ? LOCKED : OWN;
        end else begin
          own_nxt   = DEF_IDX;
          state_nxt = PARK;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= PARK;
      own_idx   <= DEF_IDX;
      beat_cnt  <= 5'd0;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else begin
      state    <= state_nxt;
      own_idx  <= own_nxt;
      beat_cnt <= beat_nxt;
      // Address phase follows the grant one accepted beat later.
      if (HREADY) begin
        HMASTER   <= own_idx;
        HMASTLOCK <= HLOCK[own_idx];
      end
    end
  end

  assign HGRANT = 4'b0001 << own_idx;

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter DEFAULT_MST, default 0: master index parked on when no request is pending (range 0..3).
REQ-002 Parameter INCR_MAX, default 16: maximum beats of an undefined-length INCR burst before arbitration is forced.
REQ-003 HCLK  in  1  bus clock; all state updates on the rising edge.
REQ-004 HRESETn  in  1  reset, asynchronous, active-low.
REQ-005 HBUSREQ  in  4  per-master bus request, bit i = master i.
REQ-006 HLOCK  in  4  per-master locked-transfer request.
REQ-007 HTRANS  in  2  transfer type of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 HBURST  in  3  burst type of the current owner (000 SINGLE, 001 INCR, 010/011 x4, 100/101 x8, 110/111 x16).
REQ-009 HREADY  in  1  bus ready from the selected slave (AHB-to-APB bridge HREADYout).
REQ-010 HGRANT  out  4  one-hot grant.
REQ-011 HMASTER  out  2  index of the address-phase owner.
REQ-012 HMASTLOCK  out  1  current owner is performing a locked sequence.

Function
REQ-013 HGRANT SHALL be one-hot at all times, never all-zero; with no request pending it SHALL park on DEFAULT_MST.
REQ-014 FSM states: PARK (no owner requesting), OWN (single transfers), BURST (fixed or INCR burst in progress), LOCKED (owner asserted HLOCK).
REQ-015 Arbitration point = HREADY=1 and one of: state PARK or OWN; BURST with last beat accepted; LOCKED with owner HLOCK deasserted; owner HBUSREQ=0 and HTRANS=IDLE.
REQ-016 At an arbitration point HGRANT SHALL update on the next HCLK edge to the winning requester; with HREADY=0 HGRANT, HMASTER and the state SHALL hold.
REQ-017 HMASTER and HMASTLOCK SHALL take the granted index and that master's HLOCK on the first HCLK edge with HREADY=1 after HGRANT changes (one-beat address-phase lag).
REQ-018 A NONSEQ with HREADY=1 and HBURST not SINGLE SHALL enter BURST and load a 5-bit beat counter: 4, 8 or 16 for fixed bursts, INCR_MAX for INCR.
REQ-019 The counter SHALL decrement on every HREADY=1 cycle with HTRANS NONSEQ or SEQ, hold on BUSY, and return to OWN at 1->0.
REQ-020 INCR SHALL also end early when the owner drops HBUSREQ and drives IDLE; reaching INCR_MAX SHALL force arbitration even with HBUSREQ held.
REQ-021 A NONSEQ from a new owner that interrupts an unfinished burst SHALL reload the counter; the counter SHALL never wrap below 0.
REQ-022 While in LOCKED no other master SHALL be granted, regardless of bursts or other requests.
REQ-023 Requests and HLOCK arriving in the same cycle as an arbitration point SHALL be included in that arbitration.

Reset
REQ-024 On HRESETn=0 asynchronously: HGRANT = one-hot(DEFAULT_MST), HMASTER = DEFAULT_MST, HMASTLOCK=0, counter 0, state PARK, priority pointer = DEFAULT_MST.
REQ-025 Reset mid-burst or mid-lock SHALL abandon the sequence with no residual state; the first request after release SHALL be arbitrated normally.

Configuration
REQ-026 Macro AHB_ARB_ROUND_ROBIN_EN defined: rotating priority; search starts at the index after the last granted master; pointer updates at each grant change.
REQ-027 Macro undefined: fixed priority, lowest index highest; no pointer register is synthesised.

Verification
REQ-028 Reset release, HBUSREQ=0000 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0, state PARK.
REQ-029 HBUSREQ=0110, master 1 NONSEQ HBURST=011 (INCR4), HREADY=1 -> HGRANT stays 0010 for 4 accepted beats; 0100 on the edge after beat 4.
REQ-030 Master 2 INCR8 with HREADY=0 for 3 cycles mid-burst and one BUSY beat -> the counter holds throughout; grant released only after 8 accepted beats.
REQ-031 HLOCK[3]=1 with HBUSREQ=1111 -> HGRANT=1000 and HMASTLOCK=1 until HLOCK[3] falls and a single transfer completes.
REQ-032 With AHB_ARB_ROUND_ROBIN_EN and HBUSREQ=1111 held, single transfers -> grant sequence 0001, 0010, 0100, 1000, 0001; without the macro -> 0001 persists.
REQ-033 HRESETn pulsed low during beat 2 of INCR16 -> outputs return immediately to the REQ-024 values; a new request is granted within 1 cycle of release.
